// File: rtl/mem_pkg.sv
// Shared types and constants for the load/store front end.
package mem_pkg;

  localparam int MEM_DEPTH  = 1024;
  localparam int WORD_BYTES = 4;
  localparam int DATA_W     = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // next count, held once saturated
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store front end: address check, wait states, one
// memory access, one-cycle response. All outputs come straight from flops.
module mem_access_unit #(
  parameter int DATA_W      = mem_pkg::DATA_W,
  parameter int DEPTH       = mem_pkg::MEM_DEPTH,
  parameter int WAIT_CYCLES = 2,
  parameter int BYTE_ADDR   = 1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [31:0]       mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_writemem,
  output logic              mem_readmem,
  input  logic [DATA_W-1:0] mem_readmem_out,
  output logic              busy,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  err_count
);

  import mem_pkg::*;

  localparam int WCNT_W = $clog2(WAIT_CYCLES + 2);

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              write_q, write_d;
  logic              err_q, err_d;
  logic [31:0]       idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [31:0]       mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_writedata_q, mem_writedata_d;
  logic              mem_writemem_q, mem_writemem_d;
  logic              mem_readmem_q, mem_readmem_d;

  logic [31:0]       idx_s;
  logic              err_s;
  logic              rd_inc_s, wr_inc_s, err_inc_s;

  // word index and reject decision for the request on the bus
  always_comb begin
    idx_s = req_addr;
    err_s = 1'b0;
    if (BYTE_ADDR != 0) begin
      idx_s = {2'b00, req_addr[31:2]};
      err_s = (req_addr[1:0] != 2'b00) || (idx_s >= 32'(DEPTH));
    end else begin
      idx_s = req_addr;
      err_s = (idx_s >= 32'(DEPTH));
    end
  end

  // next state, latched request, and outputs derived from the next state
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    write_d = write_q;
    err_d   = err_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          err_d   = err_s;
          idx_d   = idx_s;
          wdata_d = req_wdata;
          if (err_s) begin
            state_d = RESP;
          end else if (WAIT_CYCLES == 0) begin
            state_d = ACCESS;
          end else begin
            state_d = WAIT;
            wcnt_d  = WCNT_W'(WAIT_CYCLES);
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q - WCNT_W'(1);
        if (wcnt_q == WCNT_W'(1)) begin
          state_d = ACCESS;
        end else begin
          state_d = WAIT;
        end
      end
      ACCESS: begin
        if (!write_q) begin
          rdata_d = mem_readmem_out;
        end else begin
          rdata_d = rdata_q;
        end
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d     = (state_d == IDLE);
    busy_d          = (state_d != IDLE);
    rsp_valid_d     = (state_d == RESP);
    rsp_err_d       = (state_d == RESP) && err_d;
    rsp_rdata_d     = '0;
    mem_address_d   = 32'd0;
    mem_writedata_d = '0;
    mem_writemem_d  = (state_d == ACCESS) && write_d;
    mem_readmem_d   = (state_d == ACCESS) && !write_d;
    if ((state_d == RESP) && !write_d && !err_d) begin
      rsp_rdata_d = rdata_d;
    end else begin
      rsp_rdata_d = '0;
    end
    if ((state_d == WAIT) || (state_d == ACCESS)) begin
      mem_address_d   = idx_d;
      mem_writedata_d = wdata_d;
    end else begin
      mem_address_d   = 32'd0;
      mem_writedata_d = '0;
    end
  end

  // counter strobes land on the closing edge of ACCESS / RESP
  always_comb begin
    rd_inc_s  = (state_q == ACCESS) && !write_q;
    wr_inc_s  = (state_q == ACCESS) && write_q;
    err_inc_s = (state_q == RESP) && err_q;
  end

  // FSM, latched request and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      wcnt_q          <= '0;
      write_q         <= 1'b0;
      err_q           <= 1'b0;
      idx_q           <= 32'd0;
      wdata_q         <= '0;
      rdata_q         <= '0;
      req_ready_q     <= 1'b1;
      busy_q          <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_err_q       <= 1'b0;
      rsp_rdata_q     <= '0;
      mem_address_q   <= 32'd0;
      mem_writedata_q <= '0;
      mem_writemem_q  <= 1'b0;
      mem_readmem_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      wcnt_q          <= wcnt_d;
      write_q         <= write_d;
      err_q           <= err_d;
      idx_q           <= idx_d;
      wdata_q         <= wdata_d;
      rdata_q         <= rdata_d;
      req_ready_q     <= req_ready_d;
      busy_q          <= busy_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_err_q       <= rsp_err_d;
      rsp_rdata_q     <= rsp_rdata_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      mem_writemem_q  <= mem_writemem_d;
      mem_readmem_q   <= mem_readmem_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_rd_cnt  (.clk(clk), .rst_n(rst_n), .inc(rd_inc_s),  .count(rd_count));
  sat_counter #(.CNT_W(CNT_W)) u_wr_cnt  (.clk(clk), .rst_n(rst_n), .inc(wr_inc_s),  .count(wr_count));
  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (.clk(clk), .rst_n(rst_n), .inc(err_inc_s), .count(err_count));

  assign req_ready     = req_ready_q;
  assign busy          = busy_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;
  assign mem_writemem  = mem_writemem_q;
  assign mem_readmem   = mem_readmem_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench: two units (2 wait states / byte addressing, and 0 wait states /
// word addressing with 8-bit counters) each in front of a 1024-word memory.
module tb_mem_access_unit;

  logic clk;
  logic rst_n;
  logic preload;

  logic [1:0]       req_valid, req_ready, req_write, rsp_valid, rsp_err, wm, rm, busy;
  logic [1:0][31:0] req_addr, req_wdata, rsp_rdata, ma, mwd, rdo;
  logic [15:0]      rdc0, wrc0, erc0;
  logic [7:0]       rdc1, wrc1, erc1;

  logic [31:0] mem     [2][1024];
  logic [31:0] ref_mem [2][1024];
  int waitc [2] = '{2, 0};
  int bytea [2] = '{1, 0};
  int cmax  [2] = '{65535, 255};
  int ref_rd [2];
  int ref_wr [2];
  int ref_er [2];

  int errors = 0;
  int checks = 0;

  mem_access_unit #(.DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(2), .BYTE_ADDR(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .mem_address(ma[0]), .mem_writedata(mwd[0]), .mem_writemem(wm[0]), .mem_readmem(rm[0]),
    .mem_readmem_out(rdo[0]), .busy(busy[0]), .rd_count(rdc0), .wr_count(wrc0), .err_count(erc0));

  mem_access_unit #(.DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(0), .BYTE_ADDR(0), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .mem_address(ma[1]), .mem_writedata(mwd[1]), .mem_writemem(wm[1]), .mem_readmem(rm[1]),
    .mem_readmem_out(rdo[1]), .busy(busy[1]), .rd_count(rdc1), .wr_count(wrc1), .err_count(erc1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int j);
    case (j)
      999:     return 32'd5;
      1000:    return 32'd13;
      1002:    return 32'd50;
      1003:    return 32'd4;
      1004:    return 32'd12;
      default: return 32'(j * 7 + 256);
    endcase
  endfunction

  // data memory: combinational read, write on the rising edge
  assign rdo[0] = mem[0][ma[0][9:0]];
  assign rdo[1] = mem[1][ma[1][9:0]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 1024; j++) mem[i][j] <= init_val(j);
    end else begin
      for (int i = 0; i < 2; i++)
        if (wm[i]) mem[i][ma[i][9:0]] <= mwd[i];
    end
  end

  function automatic int sat(input int v, input int m);
    return (v < m) ? v + 1 : m;
  endfunction

  function automatic logic [31:0] cnt_rd(input int i);
    return (i == 0) ? {16'h0, rdc0} : {24'h0, rdc1};
  endfunction
  function automatic logic [31:0] cnt_wr(input int i);
    return (i == 0) ? {16'h0, wrc0} : {24'h0, wrc1};
  endfunction
  function automatic logic [31:0] cnt_er(input int i);
    return (i == 0) ? {16'h0, erc0} : {24'h0, erc1};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_refs();
    for (int i = 0; i < 2; i++) begin
      ref_rd[i] = 0; ref_wr[i] = 0; ref_er[i] = 0;
    end
  endtask

  // present a request in IDLE; returns at the negedge of cycle 1
  task automatic start(input int inst, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    req_valid[inst] = 1'b1;
    req_write[inst] = wr;
    req_addr[inst]  = addr;
    req_wdata[inst] = wd;
    @(negedge clk);
    req_valid[inst] = 1'b0;
  endtask

  // one full transaction checked against the reference rules
  task automatic xact(input int inst, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] idx, exp_rd;
    logic        exp_err;
    int exp_lat, got, acc, n_rd, n_wr, g;
    idx     = (bytea[inst] != 0) ? (addr >> 2) : addr;
    exp_err = ((bytea[inst] != 0) && (addr[1:0] != 2'b00)) || (idx >= 32'd1024);
    exp_lat = exp_err ? 1 : waitc[inst] + 2;
    exp_rd  = (!wr && !exp_err) ? ref_mem[inst][idx[9:0]] : 32'h0;
    g = 0;
    while (!req_ready[inst] && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("ready_wait", 32'(g < 50), 32'd1);
    start(inst, wr, addr, wd);
    chk("busy_c1", 32'(busy[inst]), 32'd1);
    chk("ready_c1", 32'(req_ready[inst]), 32'd0);
    got = -1; acc = -1; n_rd = 0; n_wr = 0;
    for (int c = 1; c <= 30 && got < 0; c++) begin
      if (rm[inst]) begin
        n_rd++; acc = c;
        chk("rd_addr", ma[inst], idx);
      end
      if (wm[inst]) begin
        n_wr++; acc = c;
        chk("wr_addr", ma[inst], idx);
        chk("wr_data", mwd[inst], wd);
      end
      if (!exp_err && c <= waitc[inst]) chk("wait_addr", ma[inst], idx);
      if (rsp_valid[inst]) begin
        got = c;
        chk("rsp_rdata", rsp_rdata[inst], exp_rd);
        chk("rsp_err", 32'(rsp_err[inst]), 32'(exp_err));
      end
      @(negedge clk);
    end
    chk("latency", 32'(got), 32'(exp_lat));
    chk("n_readmem", 32'(n_rd), 32'(!wr && !exp_err));
    chk("n_writemem", 32'(n_wr), 32'(wr && !exp_err));
    chk("access_cycle", 32'(acc), exp_err ? 32'hFFFF_FFFF : 32'(exp_lat - 1));
    chk("idle_ready", 32'(req_ready[inst]), 32'd1);
    chk("idle_rsp", 32'(rsp_valid[inst]), 32'd0);
    chk("idle_addr", ma[inst], 32'd0);
    if (exp_err) ref_er[inst] = sat(ref_er[inst], cmax[inst]);
    else if (wr) begin
      ref_wr[inst] = sat(ref_wr[inst], cmax[inst]);
      ref_mem[inst][idx[9:0]] = wd;
    end else ref_rd[inst] = sat(ref_rd[inst], cmax[inst]);
    chk("rd_count", cnt_rd(inst), 32'(ref_rd[inst]));
    chk("wr_count", cnt_wr(inst), 32'(ref_wr[inst]));
    chk("err_count", cnt_er(inst), 32'(ref_er[inst]));
  endtask

  initial begin
    int t1, t2, n;
    logic [31:0] d1, d2, addr;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    preload = 1'b1;
    rst_n   = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 1024; j++) ref_mem[i][j] = init_val(j);
    reset_refs();
    repeat (2) @(negedge clk);
    preload = 1'b0;

    // reset state
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", 32'(req_ready[i]), 32'd1);
      chk("rst_outs", {26'h0, busy[i], rsp_valid[i], rsp_err[i], wm[i], rm[i], 1'b0}, 32'd0);
      chk("rst_bus", ma[i] | mwd[i] | rsp_rdata[i], 32'd0);
    end
    chk("rst_cnt", cnt_rd(0) | cnt_wr(0) | cnt_er(0), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed: load, store/load-back, rejects
    xact(0, 1'b0, 32'd4000, 32'd0);
    chk("m1000", ref_mem[0][1000], 32'd13);
    xact(0, 1'b1, 32'd4, 32'hDEAD_BEEF);
    xact(0, 1'b0, 32'd4, 32'd0);
    xact(0, 1'b0, 32'd4001, 32'd0);
    xact(0, 1'b0, 32'd4096, 32'd0);

    // requester holds valid across two loads
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'd3996;
    t1 = -1; t2 = -1; d1 = 32'd0; d2 = 32'd0;
    for (int c = 0; c <= 12; c++) begin
      if (c == 1) req_addr[0] = 32'd4008;
      if (c >= 1 && c <= 4) chk("hold_busy", 32'(req_ready[0]), 32'd0);
      if (c == 5) chk("hold_ready5", 32'(req_ready[0]), 32'd1);
      if (rsp_valid[0]) begin
        if (t1 < 0) begin t1 = c; d1 = rsp_rdata[0]; end
        else begin t2 = c; d2 = rsp_rdata[0]; end
      end
      if (c == 9) req_valid[0] = 1'b0;
      @(negedge clk);
    end
    chk("hold_t1", 32'(t1), 32'd4);
    chk("hold_t2", 32'(t2), 32'd9);
    chk("hold_d1", d1, ref_mem[0][999]);
    chk("hold_d2", d2, ref_mem[0][1002]);
    ref_rd[0] = sat(sat(ref_rd[0], cmax[0]), cmax[0]);
    chk("hold_rdcnt", cnt_rd(0), 32'(ref_rd[0]));

    // reset during WAIT drops the store
    start(0, 1'b1, 32'd4012, 32'h77);
    rst_n = 1'b0;
    #1;
    reset_refs();
    chk("rstw_ready", 32'(req_ready[0]), 32'd1);
    chk("rstw_busy", 32'(busy[0]), 32'd0);
    chk("rstw_cnt", cnt_rd(0) | cnt_wr(0) | cnt_er(0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid[0] || wm[0] || rm[0]) n++;
    end
    chk("rstw_quiet", 32'(n), 32'd0);

    // reset during ACCESS: write strobe must drop before the edge
    start(0, 1'b1, 32'd4012, 32'h99);
    repeat (2) @(negedge clk);
    chk("rsta_wm_on", 32'(wm[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rsta_wm_off", 32'(wm[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xact(0, 1'b0, 32'd4012, 32'd0);
    chk("m1003_kept", ref_mem[0][1003], 32'd4);

    // random traffic on the byte-addressed unit
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0, 3:    addr = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        1:       addr = {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
        default: addr = 32'(32'h1000 + $urandom_range(0, 65535));
      endcase
      xact(0, 1'($urandom_range(0, 1)), addr, $urandom);
    end

    // zero-wait, word-addressed unit
    xact(1, 1'b0, 32'd1004, 32'd0);
    xact(1, 1'b0, 32'd1024, 32'd0);
    xact(1, 1'b1, 32'd7, 32'h1234_5678);
    xact(1, 1'b0, 32'd7, 32'd0);
    for (int k = 0; k < 260; k++) xact(1, 1'b0, 32'($urandom_range(0, 1023)), 32'd0);
    chk("rd_sat", cnt_rd(1), 32'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store front end that sits directly upstream of the 1024-word data memory and is the only driver of its address, writedata, writemem and readmem inputs.
- Accepts one word request at a time from the core over a valid/ready handshake.
- Converts byte addresses to word indices, inserts configurable wait states, then performs the memory access.
- Returns read data or an error flag on a one-cycle response strobe, and keeps saturating access counters.

Parameters:
DATA_W, 32, data word width
DEPTH, 1024, number of memory words; legal word index is 0..DEPTH-1
WAIT_CYCLES, 2, idle cycles inserted before each memory access (0 allowed)
BYTE_ADDR, 1, 1 = req_addr is a byte address (word = addr[31:2]); 0 = req_addr is a word index
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_write  in  1  1 = store, 0 = load
req_addr  in  32  request address
req_wdata  in  DATA_W  store data
rsp_valid  out  1  one-cycle response strobe
rsp_rdata  out  DATA_W  load data (0 for stores and errors)
rsp_err  out  1  request rejected (misaligned or out of range)
mem_address  out  32  to memory address (word index)
mem_writedata  out  DATA_W  to memory writedata
mem_writemem  out  1  to memory writemem
mem_readmem  out  1  to memory readmem
mem_readmem_out  in  DATA_W  combinational read data from memory
busy  out  1  state != IDLE
rd_count  out  CNT_W  completed loads, saturating
wr_count  out  CNT_W  completed stores, saturating
err_count  out  CNT_W  rejected requests, saturating

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE. req_ready=1; all other outputs 0; counters 0; latched addr/data/rdata 0.
  - mem_writemem drops immediately, so no write can occur on the next edge.
- FSM states: IDLE, WAIT, ACCESS, RESP. req_ready=1 only in IDLE.
- Accept: a request is accepted at the edge where req_valid & req_ready. On that edge the unit latches write, word index and wdata.
- Word index and error check:
  - Word index = BYTE_ADDR ? req_addr[31:2] : req_addr.
  - err if (BYTE_ADDR & req_addr[1:0]!=0) or word index >= DEPTH.
- IDLE transitions on accept: err → RESP; WAIT_CYCLES=0 → ACCESS; otherwise WAIT with wait counter loaded with WAIT_CYCLES.
- WAIT:
  - mem_address = latched index; mem_writemem=0; mem_readmem=0.
  - Counter decrements each cycle; when counter==1, next state is ACCESS. Exactly WAIT_CYCLES cycles are spent in WAIT.
- ACCESS (exactly 1 cycle):
  - mem_address = index; mem_writedata = wdata.
  - Store: mem_writemem=1; the memory commits at the closing edge.
  - Load: mem_readmem=1; mem_readmem_out is registered into rdata at the closing edge.
  - The matching counter increments at the closing edge (saturates at all-ones). Next state RESP.
- RESP (exactly 1 cycle, no backpressure):
  - rsp_valid=1; rsp_rdata = rdata for loads, 0 otherwise; rsp_err=1 for rejected requests.
  - err_count increments at the closing edge for rejected requests. Next state IDLE.
- Outside ACCESS: mem_writemem=0 and mem_readmem=0. mem_address and mem_writedata are 0 in IDLE/RESP.
- Latency, counting the accept cycle as cycle 0:
  - Valid request: rsp_valid in cycle WAIT_CYCLES+2.
  - Rejected request: rsp_valid in cycle 1; the memory is never touched.
- Throughput: the next request can be accepted in the cycle after RESP (IDLE), so a valid request occupies WAIT_CYCLES+3 cycles.
- req_valid while busy is ignored; the requester must hold it until accepted.
- Reset mid-operation: the in-flight request is dropped with no response and no memory write, including reset asserted during ACCESS before the edge.

Decomposition:
- Package mem_pkg holds:
  - state enum {IDLE, WAIT, ACCESS, RESP};
  - constants MEM_DEPTH=1024, WORD_BYTES=4, DATA_W=32.
- Sub-module sat_counter (parameter CNT_W; ports clk, rst_n, inc, count) is instantiated three times for rd/wr/err counters.

Test Plan:
- Memory preloaded M[1000]=13, WAIT_CYCLES=2: load byte addr 4000 → rsp_valid in cycle 4, rsp_rdata=13, rsp_err=0, rd_count=1; mem_readmem high only in cycle 3.
- Store 0xDEADBEEF to byte addr 4, then load addr 4 → second rsp_rdata=0xDEADBEEF; wr_count=1; mem_writemem high exactly one cycle.
- Load addr 4001 (misaligned) and addr 4096 (index 1024) → each gives rsp_valid in cycle 1 with rsp_err=1, rsp_rdata=0; err_count=2; mem_readmem/mem_writemem never high.
- req_valid held continuously with two loads (999→5, 1002→50) → req_ready low while busy; responses 5 then 50, 5 cycles apart; second accepted exactly one cycle after first RESP.
- Store 0x77 to index 1003 with rst_n pulsed low during WAIT, then load 1003 → rsp_rdata=4 (unchanged); counters 0 after reset except the later rd_count=1.
- WAIT_CYCLES=0 build: load index 1004 → rsp_valid in cycle 2 with rsp_rdata=12; drive 65536 loads → rd_count saturates at 0xFFFF.
